// File: rtl/dma_arb_pkg.sv
// Shared definitions for the DMA stream arbiter: FSM encoding, header
// length field position and the full byte-enable constant.
package dma_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_MSB = 31;

    // Wide enough for data widths up to 512 bits; users slice what they need.
    localparam logic [63:0] KEEP_ALL = '1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requesting source at or after
// ptr, in circular order.
module rr_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_any
);

    localparam logic [ID_W:0] NUM_SRC_L = (ID_W + 1)'(NUM_SRC);

    logic [NUM_SRC-1:0] rot;
    logic [ID_W-1:0]    idx;
    logic [ID_W:0]      sum;

    // Rotate so that bit 0 of rot corresponds to the source at ptr.
    assign rot = (req >> ptr) | (req << (NUM_SRC - int'(ptr)));

    always_comb begin
        idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (rot[i]) begin
                idx = i[ID_W-1:0];
            end
        end
    end

    // Undo the rotation: gnt_id = (idx + ptr) mod NUM_SRC.
    assign sum     = {1'b0, idx} + {1'b0, ptr};
    assign gnt_id  = (sum >= NUM_SRC_L) ? ID_W'(sum - NUM_SRC_L) : sum[ID_W-1:0];
    assign gnt_any = |req;

endmodule

// File: rtl/dma_stream_arbiter.sv
// Packet-granular round-robin mux of length-prefixed source streams onto one
// DMA write stream, generating last, keep and a source id.
module dma_stream_arbiter
    import dma_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 128,
    parameter int CNT_W   = 32,
    parameter int ID_W    = $clog2(NUM_SRC)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_SRC*DATA_W-1:0]   s_data,
    input  logic [NUM_SRC-1:0]          s_valid,
    output logic [NUM_SRC-1:0]          s_ready,
    output logic [DATA_W-1:0]           m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        m_last,
    output logic [DATA_W/8-1:0]         m_keep,
    output logic [ID_W-1:0]             m_dest,
    output logic                        busy,
    output logic [31:0]                 pkt_cnt
);

    localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_SRC - 1);

    state_t             state;
    state_t             state_nxt;
    logic [ID_W-1:0]    g;
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    gnt_id;
    logic               gnt_any;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   hdr_len;
    logic [DATA_W-1:0]  src_word [NUM_SRC];
    logic               sel_valid;
    logic               sel_hs;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign src_word[i] = s_data[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .NUM_SRC (NUM_SRC),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req     (s_valid),
        .ptr     (ptr),
        .gnt_id  (gnt_id),
        .gnt_any (gnt_any)
    );

    assign sel_valid = s_valid[g];
    assign sel_hs    = sel_valid && m_ready;
    assign hdr_len   = CNT_W'(src_word[g][HDR_LEN_MSB:HDR_LEN_LSB]);
    assign m_dest    = g;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        m_data    = '0;
        m_valid   = 1'b0;
        s_ready   = '0;
        m_keep    = '0;
        m_last    = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_any) begin
                    state_nxt = HEADER;
                end
            end
            HEADER: begin
                m_data     = src_word[g];
                m_valid    = sel_valid;
                s_ready[g] = m_ready;
                m_keep     = KEEP_ALL[DATA_W/8-1:0];
                m_last     = sel_valid && (hdr_len == '0);
                if (sel_hs) begin
                    state_nxt = (hdr_len == '0) ? IDLE : PAYLOAD;
                end
            end
            PAYLOAD: begin
                m_data     = src_word[g];
                m_valid    = sel_valid;
                s_ready[g] = m_ready;
                m_keep     = KEEP_ALL[DATA_W/8-1:0];
                m_last     = sel_valid && (cnt == CNT_W'(1));
                if (sel_hs && (cnt == CNT_W'(1))) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // m_last is only raised while the granted source is valid, so
    // m_last && m_ready is exactly the packet-completing handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            g       <= '0;
            ptr     <= '0;
            cnt     <= '0;
            pkt_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && gnt_any) begin
                g <= gnt_id;
            end
            if (state == HEADER && sel_hs) begin
                cnt <= hdr_len;
            end
            if (state == PAYLOAD && sel_hs) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (m_last && m_ready) begin
                ptr     <= (g == LAST_ID) ? '0 : g + 1'b1;
                pkt_cnt <= pkt_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_dma_stream_arbiter.sv
// Randomized scoreboard bench: a packet-level round-robin model predicts the
// output beat stream, and a monitor compares every output handshake.
module tb_dma_stream_arbiter;

    localparam int NS = 4;
    localparam int DW = 128;
    localparam int IW = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [NS*DW-1:0]   s_data;
    logic [NS-1:0]      s_valid;
    logic [NS-1:0]      s_ready;
    logic [DW-1:0]      m_data;
    logic               m_valid;
    logic               m_ready;
    logic               m_last;
    logic [DW/8-1:0]    m_keep;
    logic [IW-1:0]      m_dest;
    logic               busy;
    logic [31:0]        pkt_cnt;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] dest;
    } beat_t;

    beat_t          exp_q [$];
    beat_t          model_q [NS][$];
    logic [DW-1:0]  src_q [NS][$];
    bit             src_hdr [NS][$];
    logic [31:0]    model_pkts;
    int             mptr;
    int             checks_total;
    int             checks_passed;
    int             hs_count;
    bit             rand_ready;

    dma_stream_arbiter #(
        .NUM_SRC (NS),
        .DATA_W  (DW),
        .CNT_W   (32),
        .ID_W    (IW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_last  (m_last),
        .m_keep  (m_keep),
        .m_dest  (m_dest),
        .busy    (busy),
        .pkt_cnt (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks_total++;
        if (act === req) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Queue one packet on a source and record its beats in the model.
    task automatic applyStimulus(input int src, input int unsigned p);
        logic [DW-1:0] w;
        beat_t         b;
        w = {$urandom, $urandom, $urandom, $urandom};
        w[31:0] = p;
        src_q[src].push_back(w);
        src_hdr[src].push_back(1'b1);
        b.data = w;
        b.last = (p == 0);
        b.dest = src[IW-1:0];
        model_q[src].push_back(b);
        for (int unsigned j = 1; j <= p; j++) begin
            w = {$urandom, $urandom, $urandom, $urandom};
            src_q[src].push_back(w);
            src_hdr[src].push_back(1'b0);
            b.data = w;
            b.last = (j == p);
            model_q[src].push_back(b);
        end
        model_pkts = model_pkts + 32'd1;
    endtask

    // Reference order: whole packets, first pending source at/after mptr.
    task automatic buildExpected();
        int    pending;
        int    sel;
        beat_t b;
        pending = 0;
        for (int i = 0; i < NS; i++) pending += model_q[i].size();
        while (pending > 0) begin
            sel = -1;
            for (int k = 0; k < NS; k++) begin
                if (sel < 0 && model_q[(mptr + k) % NS].size() > 0) sel = (mptr + k) % NS;
            end
            do begin
                b = model_q[sel].pop_front();
                exp_q.push_back(b);
                pending--;
            end while (!b.last);
            mptr = (sel + 1) % NS;
        end
    endtask

    task automatic runPhase(input string name);
        buildExpected();
        for (int c = 0; c < 3000 && exp_q.size() != 0; c++) @(posedge clk);
        checkOutput({name, "_drain"}, DW'(exp_q.size()), '0);
        repeat (3) @(posedge clk);
        #2;
        checkOutput({name, "_pkt_cnt"}, DW'(pkt_cnt), DW'(model_pkts));
    endtask

    // Source drivers: header beats stay valid until taken, payload beats
    // may randomly drop valid.
    initial begin
        bit [NS-1:0] acc;
        s_valid = '0;
        s_data  = '0;
        m_ready = 1'b1;
        forever begin
            @(negedge clk);
            acc = s_valid & s_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (acc[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    void'(src_hdr[i].pop_front());
                end
                if (src_q[i].size() > 0) begin
                    s_data[i*DW +: DW] = src_q[i][0];
                    s_valid[i] = src_hdr[i][0] ? 1'b1 : ($urandom_range(0, 3) != 0);
                end else begin
                    s_data[i*DW +: DW] = '0;
                    s_valid[i] = 1'b0;
                end
            end
            m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: scoreboard compare on every output handshake plus idle,
    // bubble and stall rules.
    initial begin
        bit    prev_last;
        bit    prev_idle_req;
        beat_t e;
        prev_last     = 1'b0;
        prev_idle_req = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_last     = 1'b0;
                prev_idle_req = 1'b0;
            end else begin
                if (prev_last) checkOutput("bubble_after_last", DW'(busy), '0);
                if (prev_idle_req) checkOutput("grant_after_idle_req", DW'(busy), DW'(1));
                if (!busy) begin
                    checkOutput("idle_ctrl", DW'({m_valid, s_ready, m_last, m_keep}), '0);
                    checkOutput("idle_data", m_data, '0);
                end
                if (m_valid && !m_ready) checkOutput("stall_s_ready", DW'(s_ready), '0);
                prev_idle_req = !busy && (|s_valid);
                prev_last     = 1'b0;
                if (m_valid && m_ready) begin
                    hs_count++;
                    checkOutput("beat_expected", DW'(exp_q.size() != 0), DW'(1));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        checkOutput("beat_data", m_data, e.data);
                        checkOutput("beat_last", DW'(m_last), DW'(e.last));
                        checkOutput("beat_dest", DW'(m_dest), DW'(e.dest));
                        checkOutput("beat_keep", DW'(m_keep), DW'(16'hFFFF));
                    end
                    prev_last = m_last;
                end
            end
        end
    end

    initial begin
        int base;
        checks_total  = 0;
        checks_passed = 0;
        hs_count      = 0;
        model_pkts    = '0;
        mptr          = 0;
        rand_ready    = 1'b0;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_busy", DW'(busy), '0);
        checkOutput("reset_m_valid", DW'(m_valid), '0);
        checkOutput("reset_pkt_cnt", DW'(pkt_cnt), '0);
        checkOutput("reset_m_dest", DW'(m_dest), '0);
        reset = 1'b0;

        applyStimulus(0, 3);
        runPhase("src0_p3");

        applyStimulus(2, 0);
        runPhase("src2_p0");

        applyStimulus(0, 1);
        applyStimulus(0, 1);
        applyStimulus(1, 1);
        applyStimulus(1, 1);
        runPhase("src01_p1");

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NS; i++) applyStimulus(i, 2);
        end
        runPhase("all_p2");

        rand_ready = 1'b1;
        applyStimulus(1, 4);
        runPhase("src1_p4_bp");

        for (int n = 0; n < 40; n++) applyStimulus($urandom_range(0, NS - 1), $urandom_range(0, 6));
        runPhase("random");

        // Abandon a P=5 packet after header plus two payload beats.
        rand_ready = 1'b0;
        applyStimulus(0, 5);
        buildExpected();
        base = hs_count;
        for (int c = 0; c < 200 && hs_count < base + 3; c++) @(posedge clk);
        checkOutput("reset_setup_reached", DW'(hs_count >= base + 3), DW'(1));
        #2;
        reset = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NS; i++) begin
            src_q[i].delete();
            src_hdr[i].delete();
            model_q[i].delete();
        end
        mptr       = 0;
        model_pkts = '0;
        @(posedge clk);
        #2;
        checkOutput("midreset_m_valid", DW'(m_valid), '0);
        checkOutput("midreset_busy", DW'(busy), '0);
        checkOutput("midreset_pkt_cnt", DW'(pkt_cnt), '0);
        checkOutput("midreset_m_last", DW'(m_last), '0);
        checkOutput("midreset_m_dest", DW'(m_dest), '0);
        reset = 1'b0;

        applyStimulus(3, 1);
        runPhase("post_reset_src3");

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
